keypad_scanner: RTL and testbench

- Input-side counterpart to the multiplexed seven-segment drive: scans a 4x4 matrix keypad for the ATM front panel.
- Drives one active-low column strobe at a time and reads four active-low rows.
- Debounces a single key press and hands a 4-bit key code to the transaction controller over a valid/ready handshake.
- Sits between the panel pins and the ATM control FSM.

---
 rtl/keypad_pkg.sv | 65 ++++++
 rtl/sync_2ff.sv | 33 +++
 rtl/keypad_scanner.sv | 138 +++++++++++++
 tb/tb_keypad_scanner.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types, key-code constants and the row/column-to-code map
//             used by the 4x4 matrix keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

  // Scanner control states
  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    REPORT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } scan_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Maps a (row, column) position on the panel to its 4-bit key code.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'h0;
      4'hE:    code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // True when exactly one active-low row line is asserted.
  function automatic logic one_row_low(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  // Index of the single low row in a one-low pattern.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    case (rows)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for asynchronous level inputs, with a
//             configurable reset value so idle lines come up inactive.
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to resolve.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Scans a 4x4 active-low matrix keypad one column at a time,
//             debounces a single press and release, and offers the key code
//             to the transaction controller over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,   // cycles per column slot, >= 4
  parameter int DEBOUNCE_CNT = 50000   // stable cycles for press/release, >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held
);

  // One counter serves the slot timer and both debounce timers.
  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);

  scan_state_t   state,   state_nxt;
  logic [1:0]    col,     col_nxt;
  logic [CW-1:0] cnt,     cnt_nxt;
  logic [3:0]    pattern, pattern_nxt;
  logic [3:0]    code_nxt;
  logic [3:0]    rows_s;
  logic          single_low;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (rows_s)
  );

  assign single_low = one_row_low(rows_s);

  // Next-state logic: column stepping, press/release debounce and handshake.
  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    code_nxt    = key_code;
    case (state)
      SCAN: begin
        // Rows are only looked at at the end of a slot, once the
        // synchronizer has seen the newly strobed column.
        if (cnt == SLOT_LAST) begin
          cnt_nxt = '0;
          if (single_low) begin
            pattern_nxt = rows_s;
            state_nxt   = DEBOUNCE;
          end else begin
            col_nxt = col + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (rows_s != pattern) begin
          state_nxt = SCAN;
          col_nxt   = col + 2'd1;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          code_nxt  = key_map(low_row(pattern), col);
          state_nxt = REPORT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      REPORT: begin
        // key_valid is high throughout REPORT, so ready alone completes it.
        if (key_ready) begin
          state_nxt = WAIT_RELEASE;
          cnt_nxt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (rows_s != 4'hF) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = SCAN;
          col_nxt   = 2'd0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = SCAN;
        col_nxt   = 2'd0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; outputs are derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SCAN;
      col       <= 2'd0;
      cnt       <= '0;
      pattern   <= 4'hF;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      col_out   <= 4'hF;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      cnt       <= cnt_nxt;
      pattern   <= pattern_nxt;
      key_code  <= code_nxt;
      key_valid <= (state_nxt == REPORT);
      key_held  <= (state_nxt != SCAN);
      col_out   <= ~(4'b0001 << col_nxt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner with a physical keypad
//             model, a cycle-level behavioural reference and directed plus
//             randomized key activity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        key_ready = 1'b0;
  logic [15:0] pressed   = '0;    // bit r*4+c set = key (r,c) held down
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  int vectors     = 0;
  int miscompares = 0;
  bit rand_ready  = 1'b0;

  // Panel layout, row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int dut_reports   [$];
  int model_reports [$];

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; a low column pulls the row low.
  function automatic logic [3:0] keypad_rows(input logic [15:0] keys, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[rr*4+cc] && cols[cc] === 1'b0) r[rr] = 1'b0;
    return r;
  endfunction

  assign row_in = keypad_rows(pressed, col_out);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference: what the panel should show, stepped once per clock.
  // Activity: 0 = hunting for a key, 1 = confirming a press,
  //           2 = offering a code, 3 = waiting for all keys up.
  // ---------------------------------------------------------------------------
  logic [3:0] m_near = 4'hF, m_far = 4'hF, m_col_out = 4'hF, m_code = 4'h0, m_pat = 4'hF;
  bit         m_valid = 0, m_held = 0, live = 0;
  int         m_act = 0, m_col = 0, m_time = 0;
  bit         prev_valid = 0;
  logic [3:0] prev_code = 4'h0;

  initial begin : compare_proc
    logic [3:0] pins, seen;
    int lows, row;
    bit hs;
    forever begin
      @(posedge clk);
      pins = keypad_rows(pressed, m_col_out);
      hs   = rst_n && prev_valid && key_ready;
      if (!rst_n) begin
        m_near = 4'hF; m_far = 4'hF; m_act = 0; m_col = 0; m_time = 0;
        m_code = 4'h0; m_valid = 0; m_held = 0; m_col_out = 4'hF;
        live = 1;
      end else if (live) begin
        seen   = m_far;
        m_far  = m_near;
        m_near = pins;
        lows = 0; row = 0;
        for (int r = 0; r < 4; r++) if (seen[r] == 1'b0) begin lows++; row = r; end
        if (m_act == 0) begin
          if (m_time == SCAN_DIV - 1) begin
            m_time = 0;
            if (lows == 1) begin m_pat = seen; m_act = 1; end
            else m_col = (m_col + 1) % 4;
          end else m_time++;
        end else if (m_act == 1) begin
          if (seen != m_pat) begin m_act = 0; m_col = (m_col + 1) % 4; m_time = 0; end
          else if (m_time == DEBOUNCE_CNT - 1) begin
            m_code = 4'(keymap[row*4 + m_col]); m_act = 2; m_time = 0;
          end else m_time++;
        end else if (m_act == 2) begin
          if (key_ready) begin m_act = 3; m_time = 0; model_reports.push_back(int'(m_code)); end
        end else begin
          if (seen != 4'hF) m_time = 0;
          else if (m_time == DEBOUNCE_CNT - 1) begin m_act = 0; m_col = 0; m_time = 0; end
          else m_time++;
        end
        m_col_out = ~(4'b0001 << m_col);
        m_valid   = (m_act == 2);
        m_held    = (m_act != 0);
      end
      #1;
      if (hs) dut_reports.push_back(int'(prev_code));
      prev_valid = key_valid;
      prev_code  = key_code;
      if (live) begin
        check("col_out",   col_out,   m_col_out);
        check("key_valid", key_valid, m_valid);
        check("key_code",  key_code,  m_code);
        check("key_held",  key_held,  m_held);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change only on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_ready) key_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_valid(input int budget, input string what);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < budget) begin tick(1); n++; end
    check(what, key_valid, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((key_held !== 1'b0 || key_valid !== 1'b0) && n < budget) begin tick(1); n++; end
    check("idle_timeout", {key_held, key_valid}, 2'b00);
    tick(3);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int base, exp_codes [5];
    logic [15:0] rk;
    exp_codes = '{5, 15, 10, 1, 7};

    // Reset and the free-running column strobe
    tick(3);
    check("rst_col_out", col_out, 4'hF);
    check("rst_valid",   key_valid, 1'b0);
    check("rst_code",    key_code, 4'h0);
    check("rst_held",    key_held, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k == 1)  check("scan_e", col_out, 4'hE);
      if (k == 4)  check("scan_d", col_out, 4'hD);
      if (k == 8)  check("scan_b", col_out, 4'hB);
      if (k == 12) check("scan_7", col_out, 4'h7);
      if (k == 16) check("scan_wrap", col_out, 4'hE);
    end

    // Key "5" with ready high: one-cycle valid pulse, then release debounce
    key_ready = 1'b1;
    pressed   = 16'h0020;
    wait_valid(60, "five_valid");
    check("five_code", key_code, 4'h5);
    check("five_held", key_held, 1'b1);
    tick(1);
    check("five_pulse", key_valid, 1'b0);
    tick(20);
    check("five_no_repeat", dut_reports.size(), 1);
    pressed = '0;
    tick(9);
    check("five_release_held", key_held, 1'b1);
    tick(1);
    check("five_release_done", key_held, 1'b0);
    check("five_rescan", col_out, 4'hE);

    // Key "#" with 3-cycle bounce during its first 20 cycles
    tick(5);
    base = dut_reports.size();
    for (int i = 0; i < 20; i++) begin
      pressed = ((i / 3) % 2 == 0) ? 16'h4000 : 16'h0000;
      tick(1);
    end
    check("hash_no_early", dut_reports.size(), base);
    pressed = 16'h4000;
    wait_valid(80, "hash_valid");
    check("hash_code", key_code, 4'hF);
    tick(10);
    check("hash_once", dut_reports.size(), base + 1);
    pressed = '0;
    wait_idle(60);

    // Key "A" with ready held low: valid and code stay put
    key_ready = 1'b0;
    pressed   = 16'h0008;
    wait_valid(60, "a_valid");
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("a_hold_valid", key_valid, 1'b1);
      check("a_hold_code",  key_code, 4'hA);
    end
    base = dut_reports.size();
    key_ready = 1'b1;
    tick(1);
    check("a_handover", key_valid, 1'b0);
    check("a_accepted", dut_reports.size(), base + 1);
    pressed = '0;
    wait_idle(60);

    // "1" and "4" share column 0: two low rows, never accepted
    pressed = 16'h0011;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      check("two_rows_held", key_held, 1'b0);
    end
    pressed = '0;
    tick(5);

    // "1" then "3": first wins, no repeat while held
    pressed = 16'h0001;
    wait_valid(60, "one_valid");
    check("one_code", key_code, 4'h1);
    tick(2);
    base = dut_reports.size();
    pressed = 16'h0005;
    tick(40);
    check("one_then_three", dut_reports.size(), base);
    pressed = '0;
    wait_idle(60);

    // Reset while a code is on offer: pending key is dropped, then re-reported
    key_ready = 1'b0;
    pressed   = 16'h0100;
    wait_valid(60, "seven_valid");
    rst_n = 1'b0;
    tick(1);
    check("midrst_valid", key_valid, 1'b0);
    check("midrst_col",   col_out, 4'hF);
    check("midrst_held",  key_held, 1'b0);
    rst_n = 1'b1;
    tick(1);
    check("midrst_col0", col_out, 4'hE);
    key_ready = 1'b1;
    wait_valid(60, "seven_revalid");
    check("seven_code", key_code, 4'h7);
    tick(1);
    pressed = '0;
    wait_idle(60);

    // Pin the reference with the hand-derived report sequence
    check("model_count", model_reports.size(), 5);
    check("dut_count",   dut_reports.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < model_reports.size()) check("model_seq", model_reports[i], exp_codes[i]);
      if (i < dut_reports.size())   check("dut_seq",   dut_reports[i],   exp_codes[i]);
    end

    // Randomized presses, occasional second key, random ready
    rand_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      rk = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) rk = rk | (16'h0001 << $urandom_range(0, 15));
      pressed = rk;
      tick(int'($urandom_range(2, 45)));
      pressed = '0;
      tick(int'($urandom_range(1, 30)));
    end
    rand_ready = 1'b0;
    key_ready  = 1'b1;
    pressed    = '0;
    tick(60);
    check("final_count", dut_reports.size(), model_reports.size());
    for (int i = 0; i < dut_reports.size() && i < model_reports.size(); i++)
      check("final_seq", dut_reports[i], model_reports[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
